// File: rtl/ram_burst_writer.sv
// Burst-loaded register-file RAM with a combinational read port.
// Commands give start address and beat count; beats are written one per handshake.
module ram_burst_writer #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [ADDR_WIDTH:0]   cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [WIDTH-1:0]      wr_data,
   output logic                  busy,
   output logic                  done,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LAST = 1;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      DONE
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [ADDR_WIDTH:0]   rem;
   logic [WIDTH-1:0]      mem [DEPTH];
   logic                  cmd_fire;
   logic                  wr_fire;

   assign cmd_fire = cmd_valid & cmd_ready;
   assign wr_fire  = wr_valid & wr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               state_nxt = (cmd_len != '0) ? BURST : DONE;
            end
         end
         BURST: begin
            wr_ready = 1'b1;
            if (wr_valid && rem == LAST) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pointer wraps naturally at DEPTH; long bursts overwrite their own start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
         rem <= '0;
      end else if (cmd_fire) begin
         ptr <= cmd_addr;
         rem <= cmd_len;
      end else if (wr_fire) begin
         ptr <= ptr + 1'b1;
         rem <= rem - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_fire) begin
         mem[ptr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_ram_burst_writer.sv
// Scoreboard bench for ram_burst_writer: a reference memory model feeds
// an expected-value queue that is drained against rd_data sweeps.
module tb_ram_burst_writer;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_addr;
   logic [4:0]  cmd_len;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data;

   int checks;
   int errors;

   logic [31:0] model [16];
   logic [3:0]  mptr;
   logic [31:0] exp_q [$];
   logic [31:0] exp_v;

   ram_burst_writer #(.WIDTH(32), .ADDR_WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input logic [3:0] a, input logic [4:0] n);
      int t;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = n;
      t = 0;
      while (!cmd_ready && t < 20) begin
         step();
         t++;
      end
      checks++;
      if (!cmd_ready) begin
         errors++;
         $display("FAIL cmd_accept_timeout got=%0b want=1", cmd_ready);
      end
      step();
      cmd_valid = 1'b0;
      mptr = a;
   endtask

   task automatic do_beat(input logic [31:0] d);
      int t;
      wr_valid = 1'b1;
      wr_data  = d;
      t = 0;
      while (!wr_ready && t < 20) begin
         step();
         t++;
      end
      checks++;
      if (!wr_ready) begin
         errors++;
         $display("FAIL beat_timeout got=%0b want=1", wr_ready);
      end
      step();
      model[mptr] = d;
      mptr = mptr + 1'b1;
      wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got=%b%b%b%b want=1000",
                  cmd_ready, busy, done, wr_ready);
      end
      step();
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 16; i++) model[i] = '0;
      for (int i = 0; i < 16; i++) exp_q.push_back(model[i]);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (rd_data !== exp_v) begin
            errors++;
            $display("FAIL reset_mem[%0d] got=%h want=%h", i, rd_data, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] beats [3];
      int bcnt;
      beats[0] = 32'hA;
      beats[1] = 32'hB;
      beats[2] = 32'hC;
      do_cmd(4'd2, 5'd3);
      bcnt = 0;
      for (int k = 0; k < 3; k++) begin
         wr_valid = 1'b1;
         wr_data  = beats[k];
         rd_addr  = mptr;
         #1;
         checks++;
         if (rd_data !== model[mptr] || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_old_read[%0d] got=%h/%b want=%h/1",
                     k, rd_data, wr_ready, model[mptr]);
         end
         if (busy) bcnt++;
         step();
         model[mptr] = beats[k];
         mptr = mptr + 1'b1;
      end
      wr_valid = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done got=%b want=1", done);
      end
      if (busy) bcnt++;
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle got=%b%b want=00", done, busy);
      end
      checks++;
      if (bcnt != 4) begin
         errors++;
         $display("FAIL b2b_busy_cycles got=%0d want=4", bcnt);
      end
      for (int i = 0; i < 16; i++) exp_q.push_back(model[i]);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (rd_data !== exp_v) begin
            errors++;
            $display("FAIL b2b_mem[%0d] got=%h want=%h", i, rd_data, exp_v);
         end
      end
   endtask

   task automatic test_gaps();
      int t;
      do_cmd(4'd14, 5'd4);
      for (int k = 0; k < 4; k++) begin
         wr_valid = 1'b0;
         wr_data  = 32'hBAD0_0000 + 32'(k);
         for (int g = 0; g < 2; g++) begin
            checks++;
            if (wr_ready !== 1'b1 || done !== 1'b0) begin
               errors++;
               $display("FAIL gap_hold got=%b%b want=10", wr_ready, done);
            end
            step();
         end
         do_beat(32'(k + 1));
      end
      t = 0;
      while (!done && t < 5) begin
         step();
         t++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL gap_done got=%b want=1", done);
      end
      step();
      for (int i = 0; i < 16; i++) exp_q.push_back(model[i]);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (rd_data !== exp_v) begin
            errors++;
            $display("FAIL gap_mem[%0d] got=%h want=%h", i, rd_data, exp_v);
         end
      end
   endtask

   task automatic test_wrap_long();
      do_cmd(4'd0, 5'd18);
      for (int k = 0; k < 18; k++) do_beat(32'h100 + 32'(k));
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL wrap_done got=%b want=1", done);
      end
      step();
      for (int i = 0; i < 16; i++) exp_q.push_back(model[i]);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (rd_data !== exp_v) begin
            errors++;
            $display("FAIL wrap_mem[%0d] got=%h want=%h", i, rd_data, exp_v);
         end
      end
   endtask

   task automatic test_zero_len();
      cmd_valid = 1'b1;
      cmd_addr  = 4'd5;
      cmd_len   = 5'd0;
      step();
      cmd_len   = 5'd3;
      checks++;
      if (done !== 1'b1 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL zero_done got=%b%b want=10", done, cmd_ready);
      end
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_idle got=%b%b%b want=001", done, busy, cmd_ready);
      end
      cmd_valid = 1'b0;
      wr_valid  = 1'b1;
      wr_data   = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (busy !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_wr got=%b%b want=00", busy, wr_ready);
         end
      end
      wr_valid = 1'b0;
      for (int i = 0; i < 16; i++) exp_q.push_back(model[i]);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (rd_data !== exp_v) begin
            errors++;
            $display("FAIL zero_mem[%0d] got=%h want=%h", i, rd_data, exp_v);
         end
      end
   endtask

   task automatic test_mid_reset();
      int t;
      do_cmd(4'd3, 5'd5);
      do_beat(32'h55);
      do_beat(32'h66);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 16; i++) model[i] = '0;
      checks++;
      if (wr_ready !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_outputs got=%b%b%b want=010",
                  wr_ready, cmd_ready, busy);
      end
      for (int i = 0; i < 16; i++) exp_q.push_back(model[i]);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (rd_data !== exp_v) begin
            errors++;
            $display("FAIL midrst_mem[%0d] got=%h want=%h", i, rd_data, exp_v);
         end
      end
      step();
      rst_n = 1'b1;
      step();
      do_cmd(4'd8, 5'd2);
      do_beat(32'h77);
      do_beat(32'h88);
      t = 0;
      while (!done && t < 5) begin
         step();
         t++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL midrst_done got=%b want=1", done);
      end
      step();
      for (int i = 0; i < 16; i++) exp_q.push_back(model[i]);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (rd_data !== exp_v) begin
            errors++;
            $display("FAIL post_mem[%0d] got=%h want=%h", i, rd_data, exp_v);
         end
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      rd_addr   = '0;
      mptr      = '0;
      #11;
      test_reset();
      test_back_to_back();
      test_gaps();
      test_wrap_long();
      test_zero_len();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, errors);
      $finish;
   end

endmodule
